// File: rtl/if_fetch.sv
// Instruction fetch unit: assembles 32-bit instructions from a byte-wide memory port.
// Optional direct-mapped instruction cache enabled by defining IF_ICACHE_EN.
module if_fetch #(
    parameter logic [31:0] RST_PC       = 32'h0000_0000,
    parameter int unsigned ICACHE_LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        if_mm_req,
    output logic [31:0] if_mm_addr,
    input  logic [7:0]  mm_if_data,
    input  logic        mm_if_ok,
    input  logic        stl_id,
    input  logic        br_en,
    input  logic [31:0] br_pc,
    output logic [31:0] if_pc,
    output logic [31:0] if_is,
    output logic        stl_mm
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_bad_lines
        $error("ICACHE_LINES must be a power of two of at least 2");
    end

    logic [1:0]  state, state_n;
    logic [31:0] pc, pc_n;
    logic [1:0]  cnt, cnt_n;
    logic [31:0] asm_buf, asm_n;
    logic [31:0] if_pc_n, if_is_n;
    logic [31:0] word;
    logic        done;
    logic        fetching;

    assign word = {mm_if_data, asm_buf[23:0]};

`ifdef IF_ICACHE_EN
    localparam int unsigned IDX_W = $clog2(ICACHE_LINES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic [ICACHE_LINES-1:0] c_valid;
    logic [TAG_W-1:0]        c_tag  [ICACHE_LINES];
    logic [31:0]             c_word [ICACHE_LINES];
    logic [IDX_W-1:0]        idx;
    logic [TAG_W-1:0]        tag;
    logic                    hit;

    assign idx = pc[IDX_W+1:2];
    assign tag = pc[31:IDX_W+2];
    assign hit = c_valid[idx] && (c_tag[idx] == tag);

    // Valid bits are the only cache state that needs a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_valid <= '0;
        end else if (done) begin
            c_valid[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (done) begin
            c_tag[idx]  <= tag;
            c_word[idx] <= word;
        end
    end
`endif

    // Request address runs one byte ahead when a byte lands this cycle, so a
    // back-to-back memory can return a byte every cycle for the previous address.
    assign fetching   = (state == FETCH) && !br_en;
    assign if_mm_req  = fetching;
    assign if_mm_addr = fetching ? (pc + 32'(cnt) + 32'(mm_if_ok)) : 32'h0;
    assign stl_mm     = !((state == HOLD) && !stl_id && !br_en);

    always_comb begin
        state_n = state;
        pc_n    = pc;
        cnt_n   = cnt;
        asm_n   = asm_buf;
        if_pc_n = if_pc;
        if_is_n = if_is;
        done    = 1'b0;
        if (br_en) begin
            state_n = IDLE;
            pc_n    = br_pc & ~32'h3;
            cnt_n   = 2'd0;
            asm_n   = 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_n = 2'd0;
`ifdef IF_ICACHE_EN
                    if (hit) begin
                        state_n = HOLD;
                        if_is_n = c_word[idx];
                        if_pc_n = pc;
                    end else begin
                        state_n = FETCH;
                    end
`else
                    state_n = FETCH;
`endif
                end
                FETCH: begin
                    if (mm_if_ok) begin
                        asm_n[{cnt, 3'b000} +: 8] = mm_if_data;
                        cnt_n = cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            done    = 1'b1;
                            if_is_n = word;
                            if_pc_n = pc;
                            state_n = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stl_id) begin
                        pc_n    = pc + 32'd4;
                        state_n = FETCH;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= RST_PC;
            cnt     <= 2'd0;
            asm_buf <= 32'h0;
            if_pc   <= 32'h0;
            if_is   <= 32'h0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            cnt     <= cnt_n;
            asm_buf <= asm_n;
            if_pc   <= if_pc_n;
            if_is   <= if_is_n;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: byte memory model, scoreboard of expected instruction stream, directed and random phases.
module tb_if_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        if_mm_req;
    logic [31:0] if_mm_addr;
    logic [7:0]  mm_if_data;
    logic        mm_if_ok;
    logic        stl_id;
    logic        br_en;
    logic [31:0] br_pc;
    logic [31:0] if_pc;
    logic [31:0] if_is;
    logic        stl_mm;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_deliv  = 0;
    int          drop_pct = 0;
    logic [63:0] exp_q[$];
    logic [31:0] next_pc;

    if_fetch #(.RST_PC(RST_PC), .ICACHE_LINES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_mm_req  (if_mm_req),
        .if_mm_addr (if_mm_addr),
        .mm_if_data (mm_if_data),
        .mm_if_ok   (mm_if_ok),
        .stl_id     (stl_id),
        .br_en      (br_en),
        .br_pc      (br_pc),
        .if_pc      (if_pc),
        .if_is      (if_is),
        .stl_mm     (stl_mm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: a fixed program word at 0, hashed bytes elsewhere.
    function automatic logic [7:0] mb(input logic [31:0] a);
        logic [31:0] h;
        case (a)
            32'd0:        return 8'h13;
            32'd1:        return 8'h05;
            32'd2, 32'd3: return 8'h00;
            default:      ;
        endcase
        h = a * 32'h9E37_79B1;
        return h[31:24] ^ h[7:0];
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] p);
        return {mb(p + 32'd3), mb(p + 32'd2), mb(p + 32'd1), mb(p)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sb_fill();
        while (exp_q.size() < 8) begin
            exp_q.push_back({next_pc, word_at(next_pc)});
            next_pc = next_pc + 32'd4;
        end
    endtask

    task automatic sb_restart(input logic [31:0] p);
        exp_q.delete();
        next_pc = p;
        sb_fill();
    endtask

    // Memory: answers the previous cycle's request, or drops it with probability drop_pct.
    initial begin : mem
        logic        r;
        logic [31:0] a;
        mm_if_ok   = 1'b0;
        mm_if_data = 8'h00;
        forever begin
            @(negedge clk);
            r = if_mm_req;
            a = if_mm_addr;
            @(posedge clk);
            #1;
            if (r === 1'b1 && int'($urandom_range(99)) >= drop_pct) begin
                mm_if_ok   = 1'b1;
                mm_if_data = mb(a);
            end else begin
                mm_if_ok   = 1'b0;
                mm_if_data = 8'($urandom);
            end
        end
    end

    // Monitor: every accepted delivery must match the head of the expected stream.
    initial begin : mon
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && stl_mm === 1'b0) begin
                n_deliv++;
                if (exp_q.size() == 0) sb_fill();
                e = exp_q.pop_front();
                check("sb_pc", if_pc, e[63:32]);
                check("sb_is", if_is, e[31:0]);
                sb_fill();
            end
        end
    end

    initial begin : main
        int          n;
        logic [31:0] t;
        rst    = 1'b1;
        stl_id = 1'b0;
        br_en  = 1'b0;
        br_pc  = 32'h0;
        sb_restart(RST_PC);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stl_mm", 32'(stl_mm), 32'd1);
        check("rst_req", 32'(if_mm_req), 32'd0);
        check("rst_addr", if_mm_addr, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_is", if_is, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // First instruction from reset
        n = 0;
        do begin @(negedge clk); n++; end while (stl_mm !== 1'b0 && n < 50);
        check("first_deliver", 32'(stl_mm), 32'd0);
        check("first_is", if_is, 32'h0000_0513);
        check("first_pc", if_pc, 32'h0);
        @(negedge clk);
        check("first_one_cycle", 32'(stl_mm), 32'd1);
        check("first_next_req", 32'(if_mm_req), 32'd1);
        check("first_next_addr", if_mm_addr, 32'd4);

`ifdef IF_ICACHE_EN
        // Branch back to a cached address: IDLE then straight to HOLD
        @(posedge clk);
        #1 br_en = 1'b1; br_pc = 32'h0; sb_restart(32'h0);
        @(posedge clk);
        #1 br_en = 1'b0;
        @(negedge clk);
        check("ic_idle_req", 32'(if_mm_req), 32'd0);
        @(negedge clk);
        check("ic_hold", 32'(stl_mm), 32'd0);
        check("ic_is", if_is, 32'h0000_0513);
        check("ic_req", 32'(if_mm_req), 32'd0);
`endif

        // Downstream stall held for three cycles in HOLD
        @(posedge clk);
        #1 stl_id = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (if_pc !== 32'd4 && n < 60);
        check("stall_reach", if_pc, 32'd4);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check("stall_stl_mm", 32'(stl_mm), 32'd1);
            check("stall_req", 32'(if_mm_req), 32'd0);
            check("stall_pc", if_pc, 32'd4);
            check("stall_is", if_is, word_at(32'd4));
        end
        @(posedge clk);
        #1 stl_id = 1'b0;
        @(negedge clk);
        check("stall_release", 32'(stl_mm), 32'd0);
        @(negedge clk);
        check("after_release_req", 32'(if_mm_req), 32'd1);
        check("after_release_addr", if_mm_addr, 32'd8);

        // Branch coincident with the third byte's return
        @(negedge clk);
        check("pre_br_addr1", if_mm_addr, 32'd9);
        @(negedge clk);
        check("pre_br_addr2", if_mm_addr, 32'd10);
        @(posedge clk);
        #1 br_en = 1'b1; br_pc = 32'h0000_1002; sb_restart(32'h0000_1000);
        @(negedge clk);
        check("br_stl_mm", 32'(stl_mm), 32'd1);
        check("br_req", 32'(if_mm_req), 32'd0);
        @(posedge clk);
        #1 br_en = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (if_mm_req !== 1'b1 && n < 20);
        check("br_target_addr", if_mm_addr, 32'h0000_1000);

        // PC wrap at the top of the address space
        @(posedge clk);
        #1 br_en = 1'b1; br_pc = 32'hFFFF_FFFF; sb_restart(32'hFFFF_FFFC);
        @(posedge clk);
        #1 br_en = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end
        while (!(stl_mm === 1'b0 && if_pc === 32'hFFFF_FFFC) && n < 40);
        check("wrap_deliver_pc", if_pc, 32'hFFFF_FFFC);
        check("wrap_deliver", 32'(stl_mm), 32'd0);
        @(negedge clk);
        check("wrap_req", 32'(if_mm_req), 32'd1);
        check("wrap_addr", if_mm_addr, 32'h0);

        // Reset in the middle of a fetch (two bytes collected)
        n = 0;
        do begin @(negedge clk); n++; end
        while (!(if_mm_req === 1'b1 && if_mm_addr === 32'd3) && n < 20);
        check("mid_rst_reach", if_mm_addr, 32'd3);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_stl_mm", 32'(stl_mm), 32'd1);
        check("mid_rst_req", 32'(if_mm_req), 32'd0);
        check("mid_rst_addr", if_mm_addr, 32'h0);
        check("mid_rst_if_pc", if_pc, 32'h0);
        check("mid_rst_if_is", if_is, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0; sb_restart(RST_PC);
        n = 0;
        do begin @(negedge clk); n++; end while (if_mm_req !== 1'b1 && n < 20);
        check("mid_rst_first_addr", if_mm_addr, RST_PC);

        // Random phase: stalls, branches, dropped memory responses
        drop_pct = 20;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            stl_id = ($urandom_range(99) < 30);
            if ($urandom_range(99) < 4) begin
                case ($urandom_range(2))
                    0:       t = 32'($urandom_range(255));
                    1:       t = 32'h0000_1000 + 32'($urandom_range(255));
                    default: t = 32'hFFFF_FF00 + 32'($urandom_range(255));
                endcase
                br_en = 1'b1;
                br_pc = t;
                sb_restart(t & ~32'h3);
            end else begin
                br_en = 1'b0;
            end
        end
        @(posedge clk);
        #1 br_en = 1'b0; stl_id = 1'b0;
        repeat (5) @(negedge clk);
        check("delivery_count", 32'(n_deliv > 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RST_PC, default 32'h00000000: PC loaded on reset.
REQ-002 Parameter ICACHE_LINES, default 16: number of I-cache entries, power of two; used only with IF_ICACHE_EN.
REQ-003 clk  input  1  system clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 if_mm_req  output  1  byte-fetch request to the memory controller.
REQ-006 if_mm_addr  output  32  byte address of the current request.
REQ-007 mm_if_data  input  8  returned byte; valid when mm_if_ok=1.
REQ-008 mm_if_ok  input  1  one byte returned this cycle, for if_mm_addr of the previous cycle.
REQ-009 stl_id  input  1  downstream stall; the fetched instruction must be held.
REQ-010 br_en  input  1  redirect request from EX.
REQ-011 br_pc  input  32  redirect target.
REQ-012 if_pc  output  32  PC of the delivered instruction, feeds the IF/ID register.
REQ-013 if_is  output  32  delivered instruction word.
REQ-014 stl_mm  output  1  0 = if_pc/if_is valid, to be latched by IF/ID this edge; 1 = stall.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH and HOLD, plus a 2-bit byte counter cnt and a 32-bit assembly buffer.
REQ-016 IDLE: the FSM SHALL clear cnt, assert no request, and go to FETCH the next cycle (one-cycle bubble).
REQ-017 FETCH: the block SHALL assert if_mm_req=1 with if_mm_addr=pc+cnt.
REQ-018 FETCH: on mm_if_ok, the byte SHALL be stored at buf[8*cnt+7:8*cnt], i.e. little-endian, and cnt SHALL be incremented.
REQ-019 FETCH: on mm_if_ok with cnt=3, if_is SHALL equal the assembled word, if_pc SHALL equal pc, and the state SHALL become HOLD.
REQ-020 HOLD: stl_mm SHALL be 0 iff stl_id=0.
REQ-021 HOLD with stl_id=0: pc SHALL become pc+4, mod 2^32 wrap, and the state SHALL become FETCH.
REQ-022 HOLD with stl_id=1: HOLD SHALL be kept and if_pc/if_is held stable.
REQ-023 stl_mm SHALL be 1 in IDLE and FETCH.
REQ-024 A full fetch SHALL take 4 mm_if_ok cycles, plus 1 HOLD cycle.
REQ-025 br_en=1 in any state SHALL set pc={br_pc[31:2],2'b00}, discard buffered bytes, force stl_mm=1 that cycle, and move to IDLE.
REQ-026 br_en SHALL have priority over a simultaneous mm_if_ok, whose byte is discarded, and over a HOLD release.
REQ-027 mm_if_ok received in IDLE or HOLD SHALL be ignored.
REQ-028 if_mm_req SHALL be 0 in IDLE and HOLD.

Reset
REQ-029 rst=1 SHALL immediately set: pc=RST_PC, state=IDLE, cnt=0, buf=0, if_pc=0, if_is=0, if_mm_req=0, if_mm_addr=0, stl_mm=1.
REQ-030 Reset mid-fetch SHALL abandon the partial word; the first request after release SHALL be to RST_PC.
REQ-031 With IF_ICACHE_EN defined, reset SHALL clear all valid bits.

Configuration
REQ-032 Macro IF_ICACHE_EN SHALL control the instruction cache.
REQ-033 With IF_ICACHE_EN: ICACHE_LINES direct-mapped entries, indexed by pc[log2(ICACHE_LINES)+1:2], storing valid, tag pc[31:log2+2] and a 32-bit word.
REQ-034 With IF_ICACHE_EN, IDLE hit: the cached word SHALL go to if_is, the state SHALL go to HOLD with no memory request, and FETCH SHALL be skipped.
REQ-035 With IF_ICACHE_EN, completion of FETCH SHALL fill or overwrite the entry.
REQ-036 With IF_ICACHE_EN, br_en SHALL NOT invalidate the cache.
REQ-037 Without IF_ICACHE_EN, every instruction SHALL be fetched from memory and no cache storage SHALL be synthesized.

Verification
REQ-038 Reset release, memory returns 13,05,00,00 at addresses 0..3 with mm_if_ok each cycle -> if_is=32'h00000513, if_pc=0, stl_mm=0 for exactly one cycle, next if_mm_addr=4.
REQ-039 stl_id=1 held 3 cycles during HOLD -> if_is/if_pc stable, stl_mm=1, if_mm_req=0; on release, stl_mm=0 for one cycle, then fetch at pc+4.
REQ-040 br_en=1, br_pc=32'h00001002 coincident with the 3rd byte's mm_if_ok -> byte discarded, stl_mm=1, next request to 32'h00001000 with cnt=0.
REQ-041 pc=32'hFFFFFFFC delivered, stl_id=0 -> next if_mm_addr=32'h00000000.
REQ-042 rst asserted while cnt=2 -> outputs reset immediately; first request after release to RST_PC.
REQ-043 IF_ICACHE_EN: branch back to 0 after the first fetch -> HOLD reached 2 cycles after br_en, with no if_mm_req and if_is=32'h00000513.
